bist_controller: RTL and testbench

Self-test controller for the BIST wrapper around the circuit under test (CUT). It accepts the `bist_start` request and drives an LFSR pattern sequence into the CUT. It compacts the CUT responses in a MISR, compares the final signature against a golden value, and reports completion on `bist_end` with the verdict on `pass_nfail`. It sits inside `top_level` between the external BIST pins and the CUT input mux.

---
 rtl/bist_pkg.sv | 27 ++
 rtl/bist_controller_if.sv | 35 +++
 rtl/bist_misr.sv | 36 +++
 rtl/bist_controller.sv | 112 +++++++++++
 tb/tb_bist_controller.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/bist_pkg.sv
// Shared types and polynomial constants for the BIST controller and its MISR.
// The LFSR and MISR step functions are kept here so every file uses the same taps.
package bist_pkg;

    localparam int SIG_W = 8;
    // Feedback taps at bits 7,5,4,3: x^8 + x^6 + x^5 + x^4 + 1, period 255
    localparam logic [7:0]       LFSR_TAPS = 8'hB8;
    localparam logic [SIG_W-1:0] MISR_POLY = 8'h1D;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_e;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s,
                                                   input logic [SIG_W-1:0] d);
        return {s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? MISR_POLY : '0) ^ d;
    endfunction

endpackage

// File: rtl/bist_controller_if.sv
// Pin bundle between the BIST controller, the external BIST pins and the CUT mux.
// bist_start is a level request seen only in IDLE; bist_end/pass_nfail are held until
// bist_start drops, so no valid/ready handshake is needed on any of these signals.
interface bist_controller_if #(
    parameter int PI_W = 2,
    parameter int PO_W = 2
);
    logic            bist_start;
    logic [PO_W-1:0] cut_po;
    logic [PI_W-1:0] cut_pi;
    logic            cut_test_mode;
    logic            cut_reset;
    logic            bist_end;
    logic            pass_nfail;

    modport master (
        input  bist_start,
        input  cut_po,
        output cut_pi,
        output cut_test_mode,
        output cut_reset,
        output bist_end,
        output pass_nfail
    );

    modport slave (
        output bist_start,
        output cut_po,
        input  cut_pi,
        input  cut_test_mode,
        input  cut_reset,
        input  bist_end,
        input  pass_nfail
    );
endinterface

// File: rtl/bist_misr.sv
// 8-bit multiple-input signature register compacting CUT responses.
// sig_next is exposed so the verdict can be taken on the same edge as the last absorb.
module bist_misr
    import bist_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [SIG_W-1:0] data_in,
    output logic [SIG_W-1:0] sig,
    output logic [SIG_W-1:0] sig_next
);
    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;

    assign sig_next = misr_step(sig_q, data_in);
    assign sig      = sig_q;

    always_comb begin
        sig_d = sig_q;
        if (clear) begin
            sig_d = '0;
        end else if (enable) begin
            sig_d = sig_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end
endmodule

// File: rtl/bist_controller.sv
// BIST sequencer: drives LFSR patterns into the CUT, compacts responses in a MISR
// and reports a registered pass/fail verdict against a golden signature.
module bist_controller
    import bist_pkg::*;
#(
    parameter int               PI_W       = 2,
    parameter int               PO_W       = 2,
    parameter int               N_PATTERNS = 255,
    parameter logic [7:0]       LFSR_SEED  = 8'h01,
    parameter logic [SIG_W-1:0] GOLDEN_SIG = 8'h00
) (
    input  logic                 clk,
    input  logic                 reset,
    bist_controller_if.master    bus,
    output state_e               state_o
);
    localparam int CNT_W = $clog2(N_PATTERNS + 1);

    if (LFSR_SEED == 8'h00 || N_PATTERNS < 1 || PO_W > 8 || PO_W < 1 ||
        PI_W > 8 || PI_W < 1) begin : g_param_check
        $error("bist_controller: illegal parameter combination");
    end

    state_e           state_q, state_d;
    logic [7:0]       lfsr_q, lfsr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             end_q, end_d;
    logic             pass_q, pass_d;
    logic             misr_clear;
    logic             misr_en;
    logic [SIG_W-1:0] misr_sig;
    logic [SIG_W-1:0] misr_next;

    bist_misr u_misr (
        .clk      (clk),
        .reset    (reset),
        .clear    (misr_clear),
        .enable   (misr_en),
        .data_in  (SIG_W'(bus.cut_po)),
        .sig      (misr_sig),
        .sig_next (misr_next)
    );

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        count_d    = count_q;
        end_d      = end_q;
        pass_d     = pass_q;
        misr_clear = 1'b0;
        misr_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.bist_start) state_d = ST_INIT;
            end
            ST_INIT: begin
                lfsr_d     = LFSR_SEED;
                count_d    = '0;
                misr_clear = 1'b1;
                state_d    = ST_RUN;
            end
            ST_RUN: begin
                lfsr_d  = lfsr_step(lfsr_q);
                count_d = count_q + 1'b1;
                misr_en = 1'b1;
                if (count_q == CNT_W'(N_PATTERNS - 1)) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                // Extra absorb covers the CUT's one-cycle output latency
                misr_en = 1'b1;
                end_d   = 1'b1;
                pass_d  = (misr_next == GOLDEN_SIG);
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (!bus.bist_start) begin
                    end_d   = 1'b0;
                    pass_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            lfsr_q  <= LFSR_SEED;
            count_q <= '0;
            end_q   <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            count_q <= count_d;
            end_q   <= end_d;
            pass_q  <= pass_d;
        end
    end

    assign bus.cut_pi        = lfsr_q[PI_W-1:0];
    assign bus.cut_test_mode = !reset && (state_q == ST_INIT || state_q == ST_RUN ||
                                          state_q == ST_FLUSH);
    assign bus.cut_reset     = reset || (state_q == ST_INIT);
    assign bus.bist_end      = end_q;
    assign bus.pass_nfail    = pass_q;
    assign state_o           = state_q;

    logic unused_sig;
    assign unused_sig = ^misr_sig;
endmodule

// File: tb/tb_bist_controller.sv
// Bench for bist_controller: two instances (correct and off-by-one golden) with stub CUTs.
module tb_bist_controller;
    import bist_pkg::*;

    localparam int         PI_W  = 2;
    localparam int         PO_W  = 2;
    localparam int         N_PAT = 10;
    localparam logic [7:0] SEED  = 8'h01;

    function automatic logic [7:0] tb_lfsr(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic logic [7:0] tb_misr(input logic [7:0] m, input logic [7:0] d);
        return {m[6:0], 1'b0} ^ (m[7] ? 8'h1D : 8'h00) ^ d;
    endfunction

    // Stub CUT registers cut_pi and is cleared by cut_reset in INIT, so the MISR
    // sees 0 first, then patterns 0..N-1 (the last one during FLUSH).
    function automatic logic [7:0] model_sig(input bit stuck_bit);
        logic [7:0] l;
        logic [7:0] m;
        logic [1:0] mask;
        mask = stuck_bit ? 2'b10 : 2'b11;
        l = SEED;
        m = tb_misr(8'h00, 8'h00);
        for (int k = 0; k < N_PAT; k++) begin
            m = tb_misr(m, {6'b0, l[1:0] & mask});
            l = tb_lfsr(l);
        end
        return m;
    endfunction

    localparam logic [7:0] GOLD = model_sig(1'b0);

    logic   clk = 1'b0;
    logic   reset = 1'b1;
    logic   start = 1'b0;
    logic   stuck = 1'b0;
    state_e st_a, st_b;
    int     n_checks = 0;
    int     n_pass = 0;
    logic [PI_W-1:0] exp_q[$];

    always #5 clk = ~clk;

    bist_controller_if #(.PI_W(PI_W), .PO_W(PO_W)) bif_a ();
    bist_controller_if #(.PI_W(PI_W), .PO_W(PO_W)) bif_b ();

    assign bif_a.bist_start = start;
    assign bif_b.bist_start = start;

    bist_controller #(.PI_W(PI_W), .PO_W(PO_W), .N_PATTERNS(N_PAT),
                      .LFSR_SEED(SEED), .GOLDEN_SIG(GOLD)) dut (
        .clk(clk), .reset(reset), .bus(bif_a), .state_o(st_a));

    bist_controller #(.PI_W(PI_W), .PO_W(PO_W), .N_PATTERNS(N_PAT),
                      .LFSR_SEED(SEED), .GOLDEN_SIG(GOLD ^ 8'h01)) dut_bad (
        .clk(clk), .reset(reset), .bus(bif_b), .state_o(st_b));

    always_ff @(posedge clk) begin
        if (bif_a.cut_reset) bif_a.cut_po <= '0;
        else                 bif_a.cut_po <= bif_a.cut_pi & (stuck ? 2'b10 : 2'b11);
        if (bif_b.cut_reset) bif_b.cut_po <= '0;
        else                 bif_b.cut_po <= bif_b.cut_pi & (stuck ? 2'b10 : 2'b11);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        bit stuck;
        bit pulse;
        bit exp_a;
        bit exp_b;
    } vec_t;

    task automatic push_patterns();
        logic [7:0] l;
        l = SEED;
        exp_q.delete();
        for (int k = 0; k < N_PAT; k++) begin
            exp_q.push_back(l[PI_W-1:0]);
            l = tb_lfsr(l);
        end
    endtask

    task automatic do_run(input vec_t v);
        int cyc;
        bit seen;
        stuck = v.stuck;
        push_patterns();
        @(negedge clk);
        start = 1'b1;
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check("init_state", 32'(st_a), 32'(ST_INIT));
                check("init_cut_reset", 32'(bif_a.cut_reset), 32'd1);
                check("init_test_mode", 32'(bif_a.cut_test_mode), 32'd1);
            end
            if (v.pulse && cyc == 1) start = 1'b0;
            if (v.pulse && cyc == 5) start = 1'b1;
            if (st_a == ST_RUN) begin
                if (exp_q.size() == 0) check("cut_pi_extra", 32'd1, 32'd0);
                else check("cut_pi", 32'(bif_a.cut_pi), 32'(exp_q.pop_front()));
            end
            if (st_a == ST_FLUSH) check("flush_test_mode", 32'(bif_a.cut_test_mode), 32'd1);
            if (bif_a.bist_end) seen = 1'b1;
        end
        check("end_latency", 32'(cyc), 32'(N_PAT + 3));
        check("pass_a", 32'(bif_a.pass_nfail), 32'(v.exp_a));
        check("end_b", 32'(bif_b.bist_end), 32'd1);
        check("pass_b", 32'(bif_b.pass_nfail), 32'(v.exp_b));
        check("patterns_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        check("done_hold_state", 32'(st_a), 32'(ST_DONE));
        check("done_hold_end", 32'(bif_a.bist_end), 32'd1);
        check("done_hold_pass", 32'(bif_a.pass_nfail), 32'(v.exp_a));
        check("done_test_mode", 32'(bif_a.cut_test_mode), 32'd0);
        start = 1'b0;
        @(negedge clk);
        check("idle_state", 32'(st_a), 32'(ST_IDLE));
        check("idle_end_a", 32'(bif_a.bist_end), 32'd0);
        check("idle_pass_a", 32'(bif_a.pass_nfail), 32'd0);
        check("idle_end_b", 32'(bif_b.bist_end), 32'd0);
    endtask

    initial begin
        vec_t vecs[3];
        int   cyc;
        int   run_idx;
        vecs[0] = '{stuck: 1'b0, pulse: 1'b0, exp_a: 1'b1, exp_b: 1'b0};
        vecs[1] = '{stuck: 1'b1, pulse: 1'b0, exp_a: 1'b0, exp_b: 1'b0};
        vecs[2] = '{stuck: 1'b0, pulse: 1'b1, exp_a: 1'b1, exp_b: 1'b0};

        // Reset held 5 cycles, then idle with start low
        reset = 1'b1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_cut_reset", 32'(bif_a.cut_reset), 32'd1);
        check("rst_test_mode", 32'(bif_a.cut_test_mode), 32'd0);
        check("rst_end", 32'(bif_a.bist_end), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_state", 32'(st_a), 32'(ST_IDLE));
        check("post_rst_end", 32'(bif_a.bist_end), 32'd0);
        check("post_rst_pass", 32'(bif_a.pass_nfail), 32'd0);
        check("post_rst_test_mode", 32'(bif_a.cut_test_mode), 32'd0);
        check("post_rst_cut_reset", 32'(bif_a.cut_reset), 32'd0);
        check("post_rst_cut_pi", 32'(bif_a.cut_pi), 32'(SEED & 8'h03));
        repeat (3) @(negedge clk);
        check("idle_no_lfsr_motion", 32'(bif_a.cut_pi), 32'(SEED & 8'h03));
        check("idle_stays", 32'(st_a), 32'(ST_IDLE));

        for (int i = 0; i < 3; i++) do_run(vecs[i]);

        // Reset in the middle of RUN aborts without a verdict
        stuck = 1'b0;
        push_patterns();
        @(negedge clk);
        start = 1'b1;
        cyc = 0;
        run_idx = 0;
        while (run_idx < 6 && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (st_a == ST_RUN) begin
                check("abort_cut_pi", 32'(bif_a.cut_pi), 32'(exp_q.pop_front()));
                run_idx++;
            end
        end
        check("abort_reached_run5", 32'(run_idx), 32'd6);
        reset = 1'b1;
        @(negedge clk);
        check("abort_state", 32'(st_a), 32'(ST_IDLE));
        check("abort_end", 32'(bif_a.bist_end), 32'd0);
        check("abort_pass", 32'(bif_a.pass_nfail), 32'd0);
        check("abort_cut_reset", 32'(bif_a.cut_reset), 32'd1);
        check("abort_test_mode", 32'(bif_a.cut_test_mode), 32'd0);
        reset = 1'b0;
        start = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("abort_idle", 32'(st_a), 32'(ST_IDLE));
        do_run(vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
